k005297_mskreg_array: RTL

//  Parametrised multi-channel mask register for the bubble-memory controller: one W-bit holding

---
 rtl/k005297_mskreg_array.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/k005297_mskreg_array.sv
// rtl/k005297_mskreg_array.sv - multi-channel bubble-memory mask register with shift counter
//
// Purpose:
//   One W-bit holding latch and one W-bit shift register per channel. The CPU
//   writes holding latches; on timing-slot ticks the shift registers are either
//   reloaded from the latches or shifted LSB-first, presenting bit 0 of each
//   channel to the data path. A shift counter reports shifts since the last
//   load, with empty status and a done pulse on the final shift.
//
// Configuration:
//   MSKREG_PARITY_EN - when defined, adds o_PARITY: running XOR of the bits
//                      shifted out of each channel, cleared on load/reset.
//
// Ports:
//   i_MCLK          master clock
//   i_RST           asynchronous reset, active-high
//   i_CLK4M_PCEN_n  latch-write clock enable, active-low
//   i_CLK2M_PCEN_n  shift/load clock enable, active-low
//   i_SLOT          timing-slot strobe qualifying shift/load
//   i_4BEN_n        0: all channels shift; 1: only channel 0 shifts
//   i_WR            write holding latch i_WR_CH from i_DIN
//   i_WR_CH         latch channel select (out-of-range values ignored)
//   i_DIN           latch write data
//   i_SR_LD         load request (suppressed in boot mode)
//   i_BOOTEN_n      0: boot mode (no load, fill bit 1)
//   o_SR_LSB        bit 0 of each channel shift register
//   o_BITCNT        shifts since last load, saturating at W
//   o_EMPTY         o_BITCNT == W
//   o_DONE          one-cycle pulse on the shift that brings o_BITCNT to W
//   o_PARITY        (MSKREG_PARITY_EN only) per-channel shifted-out parity

module k005297_mskreg_array #(
    parameter int W   = 16,
    parameter int CH  = 2,
    parameter int CHW = 1
) (
    input  logic           i_MCLK,
    input  logic           i_RST,
    input  logic           i_CLK4M_PCEN_n,
    input  logic           i_CLK2M_PCEN_n,
    input  logic           i_SLOT,
    input  logic           i_4BEN_n,
    input  logic           i_WR,
    input  logic [CHW-1:0] i_WR_CH,
    input  logic [W-1:0]   i_DIN,
    input  logic           i_SR_LD,
    input  logic           i_BOOTEN_n,
    output logic [CH-1:0]  o_SR_LSB,
    output logic [5:0]     o_BITCNT,
    output logic           o_EMPTY,
    output logic           o_DONE
`ifdef MSKREG_PARITY_EN
    ,
    output logic [CH-1:0]  o_PARITY
`endif
);

    localparam logic [5:0] W6 = 6'(W);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [CH-1:0][W-1:0]    latch_q;
    logic [CH-1:0][W-1:0]    sr_q, sr_d;
    logic [5:0]              cnt_q, cnt_d;
    logic                    done_q, done_d;

    logic tick;
    logic ld;
    logic fill;

    assign tick = ~i_CLK2M_PCEN_n & i_SLOT;
    assign ld   = i_SR_LD & i_BOOTEN_n;
    // Boot mode shifts ones in so the mask opens fully once the old contents drain.
    assign fill = ~i_BOOTEN_n;

`ifdef MSKREG_PARITY_EN
    logic [CH-1:0] par_q, par_d;
`endif

    // Holding latches. A load on the same edge sees the pre-write value.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            latch_q <= '0;
        end else if (~i_CLK4M_PCEN_n & i_WR) begin
            for (int c = 0; c < CH; c++) begin
                if (i_WR_CH == CHW'(c)) begin
                    latch_q[c] <= i_DIN;
                end
            end
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= W6;
            done_q  <= 1'b0;
`ifdef MSKREG_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef MSKREG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef MSKREG_PARITY_EN
        par_d   = par_q;
`endif
        if (tick) begin
            if (ld) begin
                // Load is a restart from either state.
                sr_d    = latch_q;
                cnt_d   = 6'd0;
                state_d = RUN;
`ifdef MSKREG_PARITY_EN
                par_d   = '0;
`endif
            end else begin
                for (int c = 0; c < CH; c++) begin
                    if ((c == 0) || !i_4BEN_n) begin
                        sr_d[c] = {fill, sr_q[c][W-1:1]};
`ifdef MSKREG_PARITY_EN
                        par_d[c] = par_q[c] ^ sr_q[c][0];
`endif
                    end
                end
                // Only shifts after a load are counted; idle shifts leave the counter parked at W.
                if (state_q == RUN) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == W6 - 6'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_comb begin
        o_SR_LSB = '0;
        for (int c = 0; c < CH; c++) begin
            o_SR_LSB[c] = sr_q[c][0];
        end
    end

    assign o_BITCNT = cnt_q;
    assign o_EMPTY  = (cnt_q == W6);
    assign o_DONE   = done_q;

`ifdef MSKREG_PARITY_EN
    assign o_PARITY = par_q;
`endif

endmodule
